// File: rtl/motion_pkg.sv
// motion_pkg: definitions shared by the motion-detection pipeline.
//   - READ/WRITE state encoding used by the highlight stage
//   - pixel width and the all-zero "static" mask word
//   - default frame geometry, also used by the background-subtract stage
//   - blend_pixel(): per-byte average of two RGB words, used only when
//     MOTION_HIGHLIGHT_BLEND_EN is defined
package motion_pkg;

    localparam int PIXEL_W        = 24;
    localparam int DEFAULT_WIDTH  = 720;
    localparam int DEFAULT_HEIGHT = 540;

    localparam logic [PIXEL_W-1:0] MASK_STATIC = 24'h000000;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        WRITE = 2'd1
    } motion_state_e;

    // Two-bit state constants. The two unused codes exist so that a
    // corrupted state register has somewhere to go and recover from.
    localparam logic [1:0] ST_READ  = READ;
    localparam logic [1:0] ST_WRITE = WRITE;

    // Average each byte of a and b. The 9-bit sum keeps the carry, and
    // dropping its LSB is the divide-by-two.
    function automatic logic [PIXEL_W-1:0] blend_pixel(
        input logic [PIXEL_W-1:0] a,
        input logic [PIXEL_W-1:0] b
    );
        logic [8:0]         sum;
        logic [PIXEL_W-1:0] res;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            sum = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]};
            res[8*i +: 8] = sum[8:1];
        end
        return res;
    endfunction

endpackage

// File: rtl/motion_frame_counter.sv
// motion_frame_counter: per-frame pixel and motion statistics.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   push          - one output pixel has been written this cycle
//   motion        - the pixel being pushed was a motion pixel
//   motion_count  - motion pixels in the last completed frame (held)
//   frame_done    - one-cycle pulse in the cycle after the frame's last push
module motion_frame_counter #(
    parameter int FRAME_PIXELS = 8,
    parameter int COUNT_W      = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               motion,
    output logic [COUNT_W-1:0] motion_count,
    output logic               frame_done
);

    localparam logic [COUNT_W-1:0] LAST_PIX = COUNT_W'(FRAME_PIXELS - 1);

    logic [COUNT_W-1:0] pix_cnt;
    logic [COUNT_W-1:0] run_cnt;
    logic [COUNT_W-1:0] run_next;

    // Running count including the pixel being pushed right now; this is
    // what gets latched when the push closes a frame.
    assign run_next = run_cnt + COUNT_W'(motion);

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_cnt      <= '0;
            run_cnt      <= '0;
            motion_count <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (push) begin
                if (pix_cnt == LAST_PIX) begin
                    pix_cnt      <= '0;
                    run_cnt      <= '0;
                    motion_count <= run_next;
                    frame_done   <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + COUNT_W'(1);
                    run_cnt <= run_next;
                end
            end
        end
    end

endmodule

// File: rtl/motion_highlight.sv
// motion_highlight: reader of the motion-mask FIFO. Each transaction pops one
// mask word and one original pixel together, then pushes either the original
// pixel (static mask) or the highlight colour (motion mask) to the output FIFO.
// Per-frame motion statistics come from motion_frame_counter.
//
// Handshake: all FIFOs are show-ahead, so dout is valid whenever empty=0.
// rd_en / wr_en are combinational and high only in the cycle the word
// actually moves. The mask and frame FIFOs are always popped together, and
// only when both are non-empty. Nothing moves while reset is high.
//
// Build option: MOTION_HIGHLIGHT_BLEND_EN - when defined, motion pixels are
// the per-byte average of the original pixel and HL_COLOR instead of HL_COLOR.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   mask_rd_en/empty/dout - mask FIFO (all-zero word = static)
//   fr_rd_en/empty/dout   - original-frame FIFO
//   out_wr_en/full/din    - output FIFO; out_din is zero when not writing
//   motion_count          - motion pixels in the last completed frame
//   frame_done            - pulse after the last pixel of a frame is written
//   state_dbg             - current FSM state (ST_READ / ST_WRITE)
module motion_highlight
    import motion_pkg::*;
#(
    parameter int                 WIDTH    = DEFAULT_WIDTH,
    parameter int                 HEIGHT   = DEFAULT_HEIGHT,
    parameter logic [PIXEL_W-1:0] HL_COLOR = 24'h0000FF,
    parameter int                 COUNT_W  = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic               clock,
    input  logic               reset,
    output logic               mask_rd_en,
    input  logic               mask_empty,
    input  logic [PIXEL_W-1:0] mask_dout,
    output logic               fr_rd_en,
    input  logic               fr_empty,
    input  logic [PIXEL_W-1:0] fr_dout,
    output logic               out_wr_en,
    input  logic               out_full,
    output logic [PIXEL_W-1:0] out_din,
    output logic [COUNT_W-1:0] motion_count,
    output logic               frame_done,
    output logic [1:0]         state_dbg
);

    logic [1:0]         state;
    logic [PIXEL_W-1:0] pix;
    logic               motion_flag;
    logic               pop;
    logic               push;
    logic               is_motion;
    logic [PIXEL_W-1:0] motion_pix;
    logic [PIXEL_W-1:0] next_pix;

    assign is_motion = (mask_dout != MASK_STATIC);

`ifdef MOTION_HIGHLIGHT_BLEND_EN
    assign motion_pix = blend_pixel(fr_dout, HL_COLOR);
`else
    assign motion_pix = HL_COLOR;
`endif

    assign next_pix = is_motion ? motion_pix : fr_dout;

    // Strobes require an exact state match, so an illegal state code
    // produces no transfers while it recovers to READ.
    assign pop  = !reset && (state == ST_READ) && !mask_empty && !fr_empty;
    assign push = !reset && (state == ST_WRITE) && !out_full;

    assign mask_rd_en = pop;
    assign fr_rd_en   = pop;
    assign out_wr_en  = push;
    assign out_din    = push ? pix : '0;
    assign state_dbg  = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_READ;
            pix         <= '0;
            motion_flag <= 1'b0;
        end else begin
            case (state)
                ST_READ: begin
                    if (pop) begin
                        pix         <= next_pix;
                        motion_flag <= is_motion;
                        state       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (push) begin
                        state <= ST_READ;
                    end
                end
                default: begin
                    state <= ST_READ;
                end
            endcase
        end
    end

    motion_frame_counter #(
        .FRAME_PIXELS(WIDTH * HEIGHT),
        .COUNT_W     (COUNT_W)
    ) u_frame_counter (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .motion      (motion_flag),
        .motion_count(motion_count),
        .frame_done  (frame_done)
    );

endmodule

// File: doc/motion_highlight.md
Name: motion_highlight

Overview:
- Consumer (reader) end of the mask FIFO written by the background-subtract stage.
- Pops one mask word and one original-frame pixel per transaction.
- Writes either the original pixel or a highlight colour to the output FIFO.
- Also keeps per-frame statistics: counts motion pixels per frame and pulses at frame end, for the host/testbench image writer downstream.

Parameters:
- WIDTH, 720, pixels per line.
- HEIGHT, 540, lines per frame.
- HL_COLOR, 24'h0000FF, 24-bit colour substituted for motion pixels; applied verbatim, byte order unchanged.
- COUNT_W, $clog2(WIDTH*HEIGHT+1), width of the motion and pixel counters.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- mask_rd_en  out  1  pop strobe for the mask FIFO
- mask_empty  in  1  mask FIFO empty
- mask_dout  in  24  mask word; 24'h000000 = static, anything else = motion
- fr_rd_en  out  1  pop strobe for the original-frame FIFO
- fr_empty  in  1  frame FIFO empty
- fr_dout  in  24  original RGB pixel
- out_wr_en  out  1  push strobe for the output FIFO
- out_full  in  1  output FIFO full
- out_din  out  24  highlighted pixel
- motion_count  out  COUNT_W  motion pixels in the last completed frame
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - Outputs: mask_rd_en, fr_rd_en, out_wr_en, frame_done = 0; out_din = 0; motion_count = 0.
  - Internal: pixel counter = 0, running motion counter = 0, pixel register = 0, state = READ.
- FIFO handshake:
  - Show-ahead FIFOs; dout is valid while empty=0.
  - rd_en/wr_en are combinational strobes, asserted only in the cycle the transfer occurs.
- State READ:
  - When mask_empty=0 AND fr_empty=0 in the same cycle, assert mask_rd_en=1 and fr_rd_en=1 together.
  - In that cycle, register pix = (mask_dout != 0) ? HL_COLOR : fr_dout, and set the motion flag = (mask_dout != 0). Go to WRITE.
  - If either FIFO is empty: assert neither rd_en, stay in READ. The two FIFOs are never popped independently.
- State WRITE:
  - When out_full=0: out_wr_en=1, out_din=pix, go to READ.
  - When out_full=1: hold pix, no strobes, stay in WRITE.
  - out_din = 0 whenever out_wr_en=0.
- Latency and throughput:
  - Pixel popped in cycle N appears on out_din in cycle N+1 at the earliest.
  - Throughput: 1 pixel per 2 cycles.
- Counters (updated only on a WRITE-state push):
  - Running motion counter increments if the motion flag is set.
  - Pixel counter increments.
  - If pixel counter == WIDTH*HEIGHT-1 at the push:
    - pixel counter wraps to 0;
    - motion_count <= running count including the current pixel;
    - running count clears to 0;
    - frame_done=1 in the next cycle only.
- motion_count holds its value until the next frame completes. Max value WIDTH*HEIGHT; no saturation needed.
- Reset mid-operation: a pending pix in WRITE is discarded; nothing is pushed; counters clear; no frame_done pulse.
- Unreachable state encoding: return to READ, all strobes 0.

Optional Feature:
- Macro: MOTION_HIGHLIGHT_BLEND_EN.
- Defined: motion pixels are blended, not replaced. Each byte i of the output = (fr_dout[byte i] + HL_COLOR[byte i]) >> 1, computed with a 9-bit intermediate and truncated to 8 bits. Static pixels pass unchanged.
- Undefined: motion pixels are replaced by HL_COLOR exactly.
- Timing, counters and handshakes are identical in both builds.

Decomposition:
- Shared package motion_pkg:
  - state enum (READ, WRITE);
  - PIXEL_W=24;
  - MASK_STATIC=24'h000000;
  - default WIDTH/HEIGHT constants reused by the subtract stage.
- One sub-module, motion_frame_counter:
  - holds the pixel counter, running motion counter, motion_count latch and frame_done;
  - inputs: push strobe and motion flag.

Test Plan:
- Test 1: mask=24'h000000, fr=24'h123456, FIFOs non-empty, out_full=0 -> out_din=24'h123456 one cycle after the pop; rd strobes 1 cycle; wr strobe 1 cycle.
- Test 2: mask=24'hFFFFFF, fr=24'h808080 -> out_din=24'h0000FF. With BLEND_EN, out_din=24'h4040BF.
- Test 3: fr_empty=1 with mask_empty=0 for 5 cycles -> no rd_en on either FIFO. Release -> both pop in the same cycle.
- Test 4: out_full=1 for 4 cycles in WRITE -> out_wr_en=0 throughout, no new pops, pix held. Drop full -> single push of the held value.
- Test 5: WIDTH=4, HEIGHT=2, masks alternating static/motion over 8 pixels -> frame_done pulses exactly once after the 8th push; motion_count=4. The next frame restarts from 0.
- Test 6: assert reset while in WRITE with out_full=1 -> next cycle all outputs 0, state READ; no push; motion_count=0.
